// File: rtl/cmem_dbuf_if.sv
// Bundle of the load/swap/read signals of the double-buffered coefficient memory.
// fsm_state carries the controller state out for observation.
interface cmem_dbuf_if #(
  parameter int DATABITS = 16,
  parameter int DEPTH    = 32
);
  localparam int AW = $clog2(DEPTH);

  logic                load_start_in;
  logic                sde_in;
  logic                sd_in;
  logic                sd_out;
  logic                swap_req_in;
  logic [AW-1:0]       addr_in;
  logic [DATABITS-1:0] d_out;
  logic                busy_out;
  logic                load_done_out;
  logic                swap_ack_out;
  logic                active_bank_out;
  logic                overrun_out;
  logic [1:0]          fsm_state;

  modport master (
    output load_start_in, sde_in, sd_in, swap_req_in, addr_in,
    input  sd_out, d_out, busy_out, load_done_out, swap_ack_out,
           active_bank_out, overrun_out, fsm_state
  );

  modport slave (
    input  load_start_in, sde_in, sd_in, swap_req_in, addr_in,
    output sd_out, d_out, busy_out, load_done_out, swap_ack_out,
           active_bank_out, overrun_out, fsm_state
  );
endinterface

// File: rtl/cmem_dbuf.sv
// Double-buffered coefficient memory: serial load into the shadow bank, parallel
// reads from the active bank, bank exchange on request (deferred while loading).
module cmem_dbuf #(
  parameter int DATABITS = 16,
  parameter int DEPTH    = 32
) (
  input logic        clk,
  input logic        rst,
  cmem_dbuf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(DATABITS);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FULL = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [DATABITS-1:0] mem [2][DEPTH];
  logic [DATABITS-1:0] asm_reg, asm_nxt;
  logic [BW-1:0]       bit_cnt;
  logic [AW-1:0]       word_ptr;
  logic                active, pending;
  logic [DATABITS-1:0] d_reg;
  logic                load_done, swap_ack, overrun;
  logic                busy, shift_en, word_done, fill_done, swap_now, swap_exec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.load_start_in) begin
      state_nxt = SHIFT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        SHIFT:   if (fill_done) state_nxt = FULL;
        FULL:    if (bus.swap_req_in) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == SHIFT);
    shift_en  = busy && bus.sde_in && !bus.load_start_in;
    asm_nxt   = {asm_reg[DATABITS-2:0], bus.sd_in};
    word_done = shift_en && (bit_cnt == BW'(DATABITS - 1));
    fill_done = word_done && (word_ptr == AW'(DEPTH - 1));
    // Outside SHIFT a request swaps at once; inside SHIFT it waits for the last word.
    swap_now  = bus.swap_req_in && !busy;
    swap_exec = swap_now || (fill_done && (pending || bus.swap_req_in));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < DEPTH; w++) mem[b][w] <= '0;
      asm_reg   <= '0;
      bit_cnt   <= '0;
      word_ptr  <= '0;
      active    <= 1'b0;
      pending   <= 1'b0;
      d_reg     <= '0;
      load_done <= 1'b0;
      swap_ack  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      load_done <= fill_done;
      swap_ack  <= swap_exec;
      d_reg     <= mem[active][bus.addr_in];
      if (swap_exec) active <= ~active;

      if (swap_exec)                        pending <= 1'b0;
      else if (bus.swap_req_in && busy)     pending <= 1'b1;

      if (bus.load_start_in) begin
        word_ptr <= '0;
        overrun  <= 1'b0;
        bit_cnt  <= bus.sde_in ? BW'(1) : '0;
        asm_reg  <= bus.sde_in ? {{(DATABITS-1){1'b0}}, bus.sd_in} : '0;
      end else if (shift_en) begin
        asm_reg <= asm_nxt;
        if (word_done) begin
          mem[~active][word_ptr] <= asm_nxt;
          bit_cnt  <= '0;
          word_ptr <= word_ptr + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (state == FULL && bus.sde_in) begin
        overrun <= 1'b1;
      end
    end
  end

  assign bus.sd_out          = asm_reg[DATABITS-1];
  assign bus.d_out           = d_reg;
  assign bus.busy_out        = busy;
  assign bus.load_done_out   = load_done;
  assign bus.swap_ack_out    = swap_ack;
  assign bus.active_bank_out = active;
  assign bus.overrun_out     = overrun;
  assign bus.fsm_state       = state;
endmodule

// File: doc/cmem_dbuf.md
CMEM_DBUF -- requirements
Module: cmem_dbuf

Interface
REQ-001 Parameter DATABITS, default 16, coefficient word width in bits (>=2).
REQ-002 Parameter DEPTH, default 32, words per bank (>=2); AW = $clog2(DEPTH).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port load_start_in  input  1  begins a new serial load into the shadow bank.
REQ-006 Port sde_in  input  1  serial data enable; one bit accepted per cycle while high.
REQ-007 Port sd_in  input  1  serial data bit, MSB of each word first.
REQ-008 Port sd_out  output  1  serial chain output, MSB of the assembly register.
REQ-009 Port swap_req_in  input  1  request to exchange the active and shadow banks.
REQ-010 Port addr_in  input  AW  read address into the active bank.
REQ-011 Port d_out  output  DATABITS  registered read data.
REQ-012 Port busy_out  output  1  high while state is SHIFT.
REQ-013 Port load_done_out  output  1  one-cycle pulse when the DEPTH-th word is written.
REQ-014 Port swap_ack_out  output  1  one-cycle pulse in the cycle the active bank changes.
REQ-015 Port active_bank_out  output  1  index of the active bank.
REQ-016 Port overrun_out  output  1  sticky flag: sde_in seen while state is FULL.

Function
REQ-017 Storage SHALL be two banks of DEPTH x DATABITS registers; reads always use the active bank; serial writes always use the shadow bank.
REQ-018 FSM states SHALL be IDLE, SHIFT and FULL.
REQ-019 load_start_in in any state SHALL clear the bit counter, word pointer and assembly register, clear overrun_out and enter SHIFT.
REQ-020 If load_start_in and sde_in are high in the same cycle, sd_in SHALL be taken as bit 0 of word 0.
REQ-021 In SHIFT, each cycle with sde_in=1 SHALL shift sd_in into the assembly register LSB (contents move toward MSB) and increment the bit counter.
REQ-022 On the DATABITS-th bit, the completed word (including that bit) SHALL be written to shadow[word pointer], the bit counter SHALL wrap to 0 and the word pointer SHALL increment.
REQ-023 When word DEPTH-1 is written, the FSM SHALL enter FULL and load_done_out SHALL pulse in the following cycle.
REQ-024 sde_in in IDLE SHALL be ignored; sde_in in FULL SHALL set overrun_out and change nothing else.
REQ-025 sde_in=0 in SHIFT SHALL hold all state; no timeout exists.
REQ-026 swap_req_in outside SHIFT SHALL toggle the active bank in the next cycle, with swap_ack_out pulsing that cycle and the FSM going to IDLE.
REQ-027 swap_req_in during SHIFT SHALL set a pending flag; the swap SHALL then execute in the cycle load_done_out pulses, with swap_ack_out pulsing in the same cycle.
REQ-028 A further swap_req_in while a swap is pending SHALL be absorbed; exactly one swap SHALL occur.
REQ-029 load_start_in while a swap is pending SHALL keep the pending flag set.
REQ-030 d_out SHALL equal active[addr_in] sampled at the previous edge (latency 1); the read in the cycle of a swap SHALL use the pre-swap bank.
REQ-031 sd_out SHALL be the assembly register MSB, so bits leave DATABITS cycles after entry for daisy-chaining.

Reset
REQ-032 While rst=1, both banks, the assembly register, the counters, d_out, sd_out, busy_out, load_done_out, swap_ack_out, active_bank_out, overrun_out and the pending flag SHALL be 0, and the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-load SHALL discard the partial word and all words already loaded.

Verification (DATABITS=4, DEPTH=4)
REQ-034 Reset: assert rst, then release -> d_out=0, active_bank_out=0, busy_out=0, overrun_out=0.
REQ-035 Load and swap: load_start_in, 16 sde_in bits encoding 0x1,0x2,0x3,0x4 -> load_done_out pulses once; addr 2 reads 0x0; swap_req_in -> swap_ack_out pulses, active_bank_out=1, addr 2 reads 0x3 one cycle later.
REQ-036 Deferred swap: swap_req_in after 5 bits -> no ack; after the 16th bit, swap_ack_out and load_done_out pulse in the same cycle.
REQ-037 Overrun: 3 extra sde_in bits after FULL -> overrun_out=1, bank contents unchanged; next load_start_in clears overrun_out.
REQ-038 Mid-load reset: rst after 6 bits -> all reads 0x0, FSM in IDLE, busy_out=0.
REQ-039 Simultaneous start: load_start_in with sde_in=1 and sd_in=1, then 3 bits of 0 -> shadow[0]=0x8.
